// File: rtl/user_clk_reconf_pkg.sv
// User-clock reconfiguration shared definitions:
// CMD0/CMD1/STS0 bit positions, FSM states and the decoded CMD0 bundle.
package user_clk_reconf_pkg;

   localparam int CMD0_DATA_LSB  = 0;
   localparam int CMD0_ADDR_LSB  = 32;
   localparam int CMD0_WRITE     = 44;
   localparam int CMD0_SEQ_LSB   = 48;
   localparam int CMD0_AVMM_RSTN = 52;
   localparam int CMD0_MGMT_RST  = 56;
   localparam int CMD0_IOPLL_RST = 57;
   localparam int CMD1_SEL_LSB   = 32;
   localparam int STS0_LOCK      = 60;
   localparam int STS0_BUSY      = 61;
   localparam int STS0_ERR       = 62;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } state_t;

   typedef struct packed {
      logic [31:0] data;
      logic [9:0]  addr;
      logic        write;
      logic [1:0]  seq;
      logic        avmm_rst_n;
      logic        mgmt_reset;
      logic        iopll_reset;
   } cmd0_t;

endpackage

// File: rtl/user_clk_reconf_ctrl_if.sv
// Per-PLL reconfiguration bus bundle (AVMM, resets, lock).
// master: controller side; slave: IOPLL side.
interface user_clk_reconf_ctrl_if #(
   parameter int NUM_PLL = 2,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32
);
   logic [NUM_PLL*ADDR_W-1:0] pll_address;
   logic [NUM_PLL-1:0]        pll_write;
   logic [NUM_PLL-1:0]        pll_read;
   logic [NUM_PLL*DATA_W-1:0] pll_writedata;
   logic [NUM_PLL*DATA_W-1:0] pll_readdata;
   logic [NUM_PLL-1:0]        pll_waitrequest;
   logic [NUM_PLL-1:0]        pll_avmm_rst_n;
   logic [NUM_PLL-1:0]        pll_mgmt_reset;
   logic [NUM_PLL-1:0]        pll_iopll_reset;
   logic [NUM_PLL-1:0]        pll_locked;

   modport master (
      output pll_address, pll_write, pll_read, pll_writedata,
      output pll_avmm_rst_n, pll_mgmt_reset, pll_iopll_reset,
      input  pll_readdata, pll_waitrequest, pll_locked
   );

   modport slave (
      input  pll_address, pll_write, pll_read, pll_writedata,
      input  pll_avmm_rst_n, pll_mgmt_reset, pll_iopll_reset,
      output pll_readdata, pll_waitrequest, pll_locked
   );
endinterface

// File: rtl/user_clk_lock_sync.sv
// Two-flop synchroniser for the asynchronous PLL lock vector.
// Ports: clk, rst (async high), d (async in), q (synced out).
module user_clk_lock_sync #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/user_clk_reconf_ctrl.sv
// Multi-PLL user-clock reconfiguration controller: CMD0/CMD1 in, STS0/STS1 out,
// pll: per-PLL AVMM + resets + lock. Option: USER_CLK_RECONF_TIMEOUT_EN.
module user_clk_reconf_ctrl
   import user_clk_reconf_pkg::*;
#(
   parameter int NUM_PLL        = 2,
   parameter int ADDR_W         = 10,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd0_wr,
   input  logic [63:0] cmd0_wdata,
   input  logic        cmd1_wr,
   input  logic [63:0] cmd1_wdata,
   output logic [63:0] sts0,
   output logic [63:0] sts1,
   user_clk_reconf_ctrl_if.master pll
);
   localparam int SEL_W = (NUM_PLL > 1) ? $clog2(NUM_PLL) : 1;

   state_t              state, state_nx;
   cmd0_t               c0;
   logic [SEL_W-1:0]    sel, h_sel, sel_in;
   logic [1:0]          last_seq, h_seq;
   logic [ADDR_W-1:0]   h_addr;
   logic [DATA_W-1:0]   h_data, rdata;
   logic                h_write, err;
   logic [NUM_PLL-1:0]  avmm_rst_n_r, mgmt_r, iopll_r, lock_s;
   logic                accept, wait_sel, ack, tmo;
   logic                unused_bits;

   assign c0.data        = cmd0_wdata[CMD0_DATA_LSB +: 32];
   assign c0.addr        = cmd0_wdata[CMD0_ADDR_LSB +: 10];
   assign c0.write       = cmd0_wdata[CMD0_WRITE];
   assign c0.seq         = cmd0_wdata[CMD0_SEQ_LSB +: 2];
   assign c0.avmm_rst_n  = cmd0_wdata[CMD0_AVMM_RSTN];
   assign c0.mgmt_reset  = cmd0_wdata[CMD0_MGMT_RST];
   assign c0.iopll_reset = cmd0_wdata[CMD0_IOPLL_RST];

   assign unused_bits = ^{cmd0_wdata, cmd1_wdata, c0, TIMEOUT_CYCLES};

   user_clk_lock_sync #(.W(NUM_PLL)) u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (pll.pll_locked),
      .q   (lock_s)
   );

   // Out-of-range select saturates to the last PLL.
   always_comb begin
      sel_in = cmd1_wdata[CMD1_SEL_LSB +: SEL_W];
      if (int'(sel_in) > NUM_PLL - 1)
         sel_in = SEL_W'(NUM_PLL - 1);
   end

   assign accept   = cmd0_wr && (state == IDLE) &&
                     (c0.seq != last_seq) && c0.avmm_rst_n;
   assign wait_sel = pll.pll_waitrequest[h_sel];
   assign ack      = (state == REQ) && !wait_sel;

`ifdef USER_CLK_RECONF_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt;

   // Normal completion wins if it lands on the final watchdog cycle.
   assign tmo = (state == REQ) && wait_sel &&
                (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         if (accept)
            cnt <= '0;
         else if (state == REQ)
            cnt <= cnt + 1'b1;
         if (accept)
            err <= 1'b0;
         else if (tmo)
            err <= 1'b1;
      end
   end
`else
   assign tmo = 1'b0;
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = REQ;
         REQ:     if (ack || tmo) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel          <= '0;
         h_sel        <= '0;
         h_seq        <= '0;
         h_addr       <= '0;
         h_data       <= '0;
         h_write      <= 1'b0;
         last_seq     <= '0;
         rdata        <= '0;
         avmm_rst_n_r <= '0;
         mgmt_r       <= '0;
         iopll_r      <= '0;
      end else begin
         // Reset bits follow every CMD0 write, even while busy.
         if (cmd0_wr) begin
            avmm_rst_n_r[sel] <= c0.avmm_rst_n;
            mgmt_r[sel]       <= c0.mgmt_reset;
            iopll_r[sel]      <= c0.iopll_reset;
         end
         if (cmd1_wr && (state == IDLE))
            sel <= sel_in;
         if (accept) begin
            h_sel   <= sel;
            h_seq   <= c0.seq;
            h_addr  <= c0.addr[ADDR_W-1:0];
            h_data  <= c0.data[DATA_W-1:0];
            h_write <= c0.write;
         end
         if (ack && !h_write)
            rdata <= pll.pll_readdata[h_sel*DATA_W +: DATA_W];
         if (state == DONE)
            last_seq <= h_seq;
      end
   end

   // Strobes decode straight from state so async reset drops them at once.
   always_comb begin
      pll.pll_address   = '0;
      pll.pll_writedata = '0;
      pll.pll_write     = '0;
      pll.pll_read      = '0;
      if (state == REQ) begin
         pll.pll_write[h_sel] = h_write;
         pll.pll_read[h_sel]  = !h_write;
         pll.pll_address[h_sel*ADDR_W +: ADDR_W]   = h_addr;
         pll.pll_writedata[h_sel*DATA_W +: DATA_W] = h_data;
      end
   end

   assign pll.pll_avmm_rst_n  = avmm_rst_n_r;
   assign pll.pll_mgmt_reset  = mgmt_r;
   assign pll.pll_iopll_reset = iopll_r;

   always_comb begin
      sts0 = '0;
      sts0[DATA_W-1:0]             = rdata;
      sts0[CMD0_ADDR_LSB +: ADDR_W] = h_addr;
      sts0[CMD0_WRITE]             = h_write;
      sts0[CMD0_SEQ_LSB +: 2]      = last_seq;
      sts0[CMD0_AVMM_RSTN]         = avmm_rst_n_r[sel];
      sts0[CMD0_MGMT_RST]          = mgmt_r[sel];
      sts0[CMD0_IOPLL_RST]         = iopll_r[sel];
      sts0[STS0_LOCK]              = lock_s[sel];
      sts0[STS0_BUSY]              = (state != IDLE);
      sts0[STS0_ERR]               = err;
   end

   always_comb begin
      sts1 = '0;
      sts1[NUM_PLL-1:0]            = lock_s;
      sts1[CMD1_SEL_LSB +: SEL_W]  = sel;
   end
endmodule

// File: tb/tb_user_clk_reconf_ctrl.sv
// Bench for user_clk_reconf_ctrl: directed plus random CMD0/CMD1 traffic
// against a transaction-level model of the register and PLL behaviour.
module tb_user_clk_reconf_ctrl;
   localparam int NP = 3;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd0_wr, cmd1_wr;
   logic [63:0] cmd0_wdata, cmd1_wdata, sts0, sts1;

   always #5 clk = ~clk;

   user_clk_reconf_ctrl_if #(.NUM_PLL(NP), .ADDR_W(AW), .DATA_W(DW)) pif ();

   user_clk_reconf_ctrl #(
      .NUM_PLL(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd0_wr    (cmd0_wr),
      .cmd0_wdata (cmd0_wdata),
      .cmd1_wr    (cmd1_wr),
      .cmd1_wdata (cmd1_wdata),
      .sts0       (sts0),
      .sts1       (sts1),
      .pll        (pif)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // PLL responder: waitrequest stays high for wait_n strobe cycles.
   int            wait_n = 0;
   int            wcnt[NP];
   int            wr_cnt[NP];
   int            rd_cnt[NP];
   logic [AW-1:0] seen_addr[NP];
   logic [DW-1:0] seen_data[NP];
   logic [DW-1:0] rd_val[NP];

   always @(posedge clk) begin
      for (int i = 0; i < NP; i++) begin
         if (pif.pll_write[i] || pif.pll_read[i]) begin
            wcnt[i] <= wcnt[i] + 1;
            if (pif.pll_write[i]) wr_cnt[i] <= wr_cnt[i] + 1;
            if (pif.pll_read[i])  rd_cnt[i] <= rd_cnt[i] + 1;
            seen_addr[i] <= pif.pll_address[i*AW +: AW];
            seen_data[i] <= pif.pll_writedata[i*DW +: DW];
         end else begin
            wcnt[i] <= 0;
         end
      end
   end

   always_comb begin
      pif.pll_waitrequest = '0;
      pif.pll_readdata    = '0;
      for (int i = 0; i < NP; i++) begin
         pif.pll_waitrequest[i] = (wcnt[i] < wait_n);
         pif.pll_readdata[i*DW +: DW] = rd_val[i];
      end
   end

   // Reference model state.
   int            m_sel = 0;
   logic [1:0]    m_seq = 0;
   logic [AW-1:0] m_addr = 0;
   logic          m_write = 0;
   logic [DW-1:0] m_rdata = 0;
   logic          m_err = 0;
   logic [NP-1:0] m_avmm = 0, m_mgmt = 0, m_iopll = 0, lock = 0;
   int            p_sel;
   logic [1:0]    p_seq;
   logic [AW-1:0] p_addr;
   logic [DW-1:0] p_data;
   logic          p_write;
   int            s_wr[NP], s_rd[NP];

   function automatic logic [63:0] mk0(input logic [31:0] d,
      input logic [9:0] a, input logic w, input logic [1:0] s,
      input logic av, input logic mg, input logic io);
      logic [63:0] v = '0;
      v[31:0] = d; v[41:32] = a; v[44] = w; v[49:48] = s;
      v[52] = av; v[56] = mg; v[57] = io;
      return v;
   endfunction

   function automatic logic [63:0] exp_sts0();
      logic [63:0] s = '0;
      s[31:0] = m_rdata; s[41:32] = m_addr; s[44] = m_write;
      s[49:48] = m_seq; s[52] = m_avmm[m_sel]; s[56] = m_mgmt[m_sel];
      s[57] = m_iopll[m_sel]; s[60] = lock[m_sel]; s[62] = m_err;
      return s;
   endfunction

   function automatic logic [63:0] exp_sts1();
      logic [63:0] s = '0;
      s[NP-1:0] = lock;
      s[33:32] = 2'(m_sel);
      return s;
   endfunction

   function automatic bit times_out();
`ifdef USER_CLK_RECONF_TIMEOUT_EN
      return wait_n >= TO;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_cmd0(input logic [63:0] w, input bit busy,
                             output bit acc);
      m_avmm[m_sel]  = w[52];
      m_mgmt[m_sel]  = w[56];
      m_iopll[m_sel] = w[57];
      acc = !busy && (w[49:48] != m_seq) && w[52];
      if (acc) begin
         p_sel = m_sel; p_seq = w[49:48]; p_addr = w[41:32];
         p_data = w[31:0]; p_write = w[44];
      end
   endtask

   task automatic pulse0(input logic [63:0] w);
      @(negedge clk);
      cmd0_wdata = w; cmd0_wr = 1'b1;
      @(negedge clk);
      cmd0_wr = 1'b0;
   endtask

   task automatic pulse1(input int v, input bit busy);
      @(negedge clk);
      cmd1_wdata = '0; cmd1_wdata[33:32] = 2'(v); cmd1_wr = 1'b1;
      @(negedge clk);
      cmd1_wr = 1'b0;
      if (!busy) m_sel = (v > NP - 1) ? NP - 1 : v;
   endtask

   task automatic wait_idle();
      bit stuck = 1'b1;
      for (int k = 0; k < 200; k++) begin
         if (!sts0[61]) begin stuck = 1'b0; break; end
         @(negedge clk);
      end
      chk("idle_wait", stuck, 1'b0);
   endtask

   task automatic snap();
      for (int i = 0; i < NP; i++) begin
         s_wr[i] = wr_cnt[i]; s_rd[i] = rd_cnt[i];
      end
   endtask

   task automatic finish_txn(input bit acc);
      logic [63:0] got = '0, exp = '0;
      int len;
      bit to;
      to  = times_out();
      len = to ? TO : wait_n + 1;
      for (int i = 0; i < NP; i++) begin
         got[i*16 +: 8]   = 8'(wr_cnt[i] - s_wr[i]);
         got[i*16+8 +: 8] = 8'(rd_cnt[i] - s_rd[i]);
         if (acc && i == p_sel) begin
            if (p_write) exp[i*16 +: 8] = 8'(len);
            else         exp[i*16+8 +: 8] = 8'(len);
         end
      end
      chk("strobes", got, exp);
      if (acc) begin
         chk("addr", 64'(seen_addr[p_sel]), 64'(p_addr));
         if (p_write) chk("wdata", 64'(seen_data[p_sel]), 64'(p_data));
         m_seq = p_seq; m_addr = p_addr; m_write = p_write; m_err = to;
         if (!p_write && !to) m_rdata = rd_val[p_sel];
      end
      chk("sts0", sts0, exp_sts0());
      chk("sts1", sts1, exp_sts1());
      chk("rst_vec", {pif.pll_iopll_reset, pif.pll_mgmt_reset,
                      pif.pll_avmm_rst_n}, {m_iopll, m_mgmt, m_avmm});
   endtask

   task automatic run_txn(input logic [63:0] w);
      bit acc;
      snap();
      model_cmd0(w, 1'b0, acc);
      pulse0(w);
      chk("busy", sts0[61], acc);
      wait_idle();
      finish_txn(acc);
   endtask

   initial begin
      bit acc, acc2;
      logic [63:0] w;
      rst = 1'b1; cmd0_wr = 0; cmd1_wr = 0;
      cmd0_wdata = '0; cmd1_wdata = '0; pif.pll_locked = '0;
      for (int i = 0; i < NP; i++) rd_val[i] = '0;
      repeat (3) @(negedge clk);
      chk("rst_sts0", sts0, 64'h0);
      chk("rst_sts1", sts1, 64'h0);
      chk("rst_avmm_n", 64'(pif.pll_avmm_rst_n), 64'h0);
      chk("rst_stb", 64'({pif.pll_write, pif.pll_read}), 64'h0);
      rst = 1'b0;

      @(negedge clk);
      lock = 3'b010; pif.pll_locked = lock;
      @(negedge clk);
      chk("lock_early", sts1[NP-1:0], 3'b000);
      @(negedge clk);
      chk("lock_sync", sts1[NP-1:0], lock);

      wait_n = 3;
      run_txn(mk0(32'h42, 10'h104, 1, 1, 1, 0, 0));

      pulse1(1, 0);
      wait_n = 1; rd_val[1] = 32'hA5A5_0003;
      run_txn(mk0(32'h0, 10'h058, 0, 2, 1, 0, 0));

      wait_n = 0;
      run_txn(mk0(32'h7, 10'h3, 1, 2, 1, 0, 1));

      wait_n = 4;
      snap();
      w = mk0(32'h1234, 10'h21, 1, 3, 1, 1, 0);
      model_cmd0(w, 1'b0, acc);
      pulse0(w);
      chk("busy_1st", sts0[61], acc);
      w = mk0(32'hdead, 10'h3ff, 0, 0, 1, 0, 1);
      model_cmd0(w, 1'b1, acc2);
      pulse0(w);
      pulse1(0, 1);
      wait_idle();
      finish_txn(acc);

      wait_n = 2;
      run_txn(mk0(32'h55, 10'h11, 1, 0, 1, 0, 0));

      pulse1(3, 0);
      wait_n = 1; rd_val[2] = 32'h0bad_cafe;
      run_txn(mk0(32'h0, 10'h2aa, 0, 1, 1, 0, 0));

`ifdef USER_CLK_RECONF_TIMEOUT_EN
      wait_n = 40;
      run_txn(mk0(32'h0, 10'h1, 0, 2, 1, 0, 0));
`endif

      for (int it = 0; it < 40; it++) begin
         if ($urandom % 3 == 0) pulse1(int'($urandom % 4), 0);
         wait_n = int'($urandom % 5);
         for (int i = 0; i < NP; i++) rd_val[i] = $urandom;
         run_txn(mk0($urandom, 10'($urandom), 1'($urandom),
                     2'($urandom), ($urandom % 8) != 0,
                     1'($urandom), 1'($urandom)));
      end

      wait_n = 50;
      pulse0(mk0(32'h9, 10'h9, 1, 2'(m_seq + 1), 1, 0, 0));
      repeat (3) @(negedge clk);
      chk("pre_rst_stb", 64'(|{pif.pll_write, pif.pll_read}), 64'h1);
      rst = 1'b1;
      #1;
      chk("mid_rst_stb", 64'({pif.pll_write, pif.pll_read}), 64'h0);
      chk("mid_rst_sts0", sts0, 64'h0);
      chk("mid_rst_sts1", sts1, 64'h0);
      @(negedge clk);
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
